// File: rtl/sysid_check_ctrl.sv
// Boot-time sysid checker: reads ID and timestamp words over an Avalon-MM master,
// compares them to build-time constants, retries on mismatch/stall, reports sticky status.
module sysid_check_ctrl #(
    parameter logic [31:0] EXPECTED_ID    = 32'd2,
    parameter logic [31:0] EXPECTED_TS    = 32'd1504073683,
    parameter int          MAX_RETRIES    = 3,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        av_address,
    output logic        av_read,
    input  logic [31:0] av_readdata,
    input  logic        av_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [3:0]  retry_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD_ID = 3'd1;
    localparam logic [2:0] S_RD_TS = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [3:0]  MAX_RETRY_LIM = 4'(MAX_RETRIES);
    localparam logic [15:0] TMO_LAST      = 16'(TIMEOUT_CYCLES - 1);

    logic [2:0]  state;
    logic [15:0] tmo_cnt;
    logic        retry_avail;
    logic        id_match;
    logic        ts_match;

    // Handshake: a read transfer completes on any cycle where av_read=1 and
    // av_waitrequest=0; address and strobe only move on that edge or on timeout.
    assign retry_avail = (retry_count < MAX_RETRY_LIM);
    assign id_match    = (id_value == EXPECTED_ID);
    assign ts_match    = (ts_value == EXPECTED_TS);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            tmo_cnt     <= 16'd0;
            av_address  <= 1'b0;
            av_read     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= 32'd0;
            ts_value    <= 32'd0;
            retry_count <= 4'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        retry_count <= 4'd0;
                        pass        <= 1'b0;
                        id_ok       <= 1'b0;
                        ts_ok       <= 1'b0;
                        timeout_err <= 1'b0;
                        tmo_cnt     <= 16'd0;
                        state       <= S_RD_ID;
                        av_read     <= 1'b1;
                        av_address  <= 1'b0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end
                end

                S_RD_ID, S_RD_TS: begin
                    if (!av_waitrequest) begin
                        tmo_cnt <= 16'd0;
                        if (state == S_RD_ID) begin
                            id_value   <= av_readdata;
                            av_address <= 1'b1;
                            state      <= S_RD_TS;
                        end else begin
                            ts_value   <= av_readdata;
                            av_address <= 1'b0;
                            av_read    <= 1'b0;
                            state      <= S_CHECK;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        // A stalled read aborts the whole attempt; stale compares are dropped.
                        id_ok   <= 1'b0;
                        ts_ok   <= 1'b0;
                        tmo_cnt <= 16'd0;
                        if (retry_avail) begin
                            retry_count <= retry_count + 4'd1;
                            timeout_err <= 1'b0;
                            av_read     <= 1'b1;
                            av_address  <= 1'b0;
                            state       <= S_RD_ID;
                        end else begin
                            timeout_err <= 1'b1;
                            pass        <= 1'b0;
                            av_read     <= 1'b0;
                            av_address  <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            state       <= S_DONE;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end

                S_CHECK: begin
                    id_ok <= id_match;
                    ts_ok <= ts_match;
                    if (id_match && ts_match) begin
                        pass  <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (retry_avail) begin
                        retry_count <= retry_count + 4'd1;
                        timeout_err <= 1'b0;
                        tmo_cnt     <= 16'd0;
                        av_read     <= 1'b1;
                        av_address  <= 1'b0;
                        state       <= S_RD_ID;
                    end else begin
                        pass  <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end

                default: begin
                    state      <= S_IDLE;
                    av_read    <= 1'b0;
                    av_address <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Directed bench for sysid_check_ctrl: a behavioural Avalon slave with stall and bad-data
// knobs, plus a second instance (short timeout, one retry) held in permanent stall.
module tb_sysid_check_ctrl;

    localparam logic [31:0] EXP_ID = 32'd2;
    localparam logic [31:0] EXP_TS = 32'd1504073683;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // main instance
    logic        reset_n;
    logic        start;
    logic        av_address;
    logic        av_read;
    logic [31:0] av_readdata;
    logic        av_waitrequest;
    logic        busy, done, pass, id_ok, ts_ok, timeout_err;
    logic [31:0] id_value, ts_value;
    logic [3:0]  retry_count;

    // timeout instance
    logic        reset_n_t;
    logic        start_t;
    logic        av_address_t;
    logic        av_read_t;
    logic [31:0] av_readdata_t;
    logic        av_waitrequest_t;
    logic        busy_t, done_t, pass_t, id_ok_t, ts_ok_t, timeout_err_t;
    logic [31:0] id_value_t, ts_value_t;
    logic [3:0]  retry_count_t;

    // slave knobs
    logic        id_bad;
    int          stall_n;
    int          bad_ts_n;
    int          ts_bad_base;
    int          ts_reads;
    int          wait_cnt;

    int          n_cmp;
    int          n_err;

    sysid_check_ctrl dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .av_address(av_address), .av_read(av_read),
        .av_readdata(av_readdata), .av_waitrequest(av_waitrequest),
        .busy(busy), .done(done), .pass(pass), .id_ok(id_ok), .ts_ok(ts_ok),
        .timeout_err(timeout_err), .id_value(id_value), .ts_value(ts_value),
        .retry_count(retry_count)
    );

    sysid_check_ctrl #(.MAX_RETRIES(1), .TIMEOUT_CYCLES(8)) dut_t (
        .clock(clock), .reset_n(reset_n_t), .start(start_t),
        .av_address(av_address_t), .av_read(av_read_t),
        .av_readdata(av_readdata_t), .av_waitrequest(av_waitrequest_t),
        .busy(busy_t), .done(done_t), .pass(pass_t), .id_ok(id_ok_t), .ts_ok(ts_ok_t),
        .timeout_err(timeout_err_t), .id_value(id_value_t), .ts_value(ts_value_t),
        .retry_count(retry_count_t)
    );

    // Behavioural slave: stalls stall_n cycles per read, optional bad data
    assign av_waitrequest = av_read && (wait_cnt < stall_n);
    assign av_readdata    = av_address ? (((ts_reads - ts_bad_base) < bad_ts_n) ? 32'h1234_5678 : EXP_TS)
                                       : (id_bad ? 32'd3 : EXP_ID);

    always @(posedge clock) begin
        if (av_read && av_waitrequest) wait_cnt <= wait_cnt + 1;
        else                           wait_cnt <= 0;
        if (av_read && !av_waitrequest && av_address) ts_reads <= ts_reads + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Drive start for one cycle; returns in the cycle right after the sampling edge.
    task automatic pulse_start(input bit sel);
        if (sel) start_t = 1'b1; else start = 1'b1;
        next_cycle();
        start   = 1'b0;
        start_t = 1'b0;
    endtask

    // k = cycle index (1 = first cycle after the start edge) at which done is seen.
    task automatic wait_done(input bit sel, input int limit, output int k);
        k = 1;
        while (((sel ? done_t : done) !== 1'b1) && k < limit) begin
            next_cycle();
            k++;
        end
        if ((sel ? done_t : done) !== 1'b1) check_val("done_wait", 32'd0, 32'd1);
    endtask

    initial begin
        int k;
        n_cmp = 0; n_err = 0;
        wait_cnt = 0; ts_reads = 0; ts_bad_base = 0;
        id_bad = 1'b0; stall_n = 0; bad_ts_n = 0;
        start = 1'b0; start_t = 1'b0;
        reset_n = 1'b0; reset_n_t = 1'b0;
        av_waitrequest_t = 1'b1;
        av_readdata_t    = 32'd0;
        repeat (3) next_cycle();

        // reset state
        check_val("rst_av_read", 32'(av_read), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_pass", 32'(pass), 32'd0);
        check_val("rst_id_value", id_value, 32'd0);
        check_val("rst_retry", 32'(retry_count), 32'd0);
        check_val("rst_t_av_read", 32'(av_read_t), 32'd0);
        reset_n = 1'b1; reset_n_t = 1'b1;
        next_cycle();

        // zero-wait good image
        pulse_start(1'b0);
        check_val("zw_c1_read", 32'(av_read), 32'd1);
        check_val("zw_c1_addr", 32'(av_address), 32'd0);
        check_val("zw_c1_busy", 32'(busy), 32'd1);
        next_cycle();
        check_val("zw_c2_read", 32'(av_read), 32'd1);
        check_val("zw_c2_addr", 32'(av_address), 32'd1);
        next_cycle();
        check_val("zw_c3_read", 32'(av_read), 32'd0);
        check_val("zw_c3_done", 32'(done), 32'd0);
        next_cycle();
        check_val("zw_c4_done", 32'(done), 32'd1);
        check_val("zw_pass", 32'(pass), 32'd1);
        check_val("zw_busy", 32'(busy), 32'd0);
        check_val("zw_retry", 32'(retry_count), 32'd0);
        check_val("zw_id_value", id_value, EXP_ID);
        check_val("zw_ts_value", ts_value, EXP_TS);
        check_val("zw_id_ok", 32'(id_ok), 32'd1);
        check_val("zw_ts_ok", 32'(ts_ok), 32'd1);

        // bad ID every time: 4 attempts x 3 cycles, done at cycle 13
        id_bad = 1'b1;
        pulse_start(1'b0);
        wait_done(1'b0, 100, k);
        check_val("badid_cycles", 32'(k), 32'd13);
        check_val("badid_pass", 32'(pass), 32'd0);
        check_val("badid_id_ok", 32'(id_ok), 32'd0);
        check_val("badid_ts_ok", 32'(ts_ok), 32'd1);
        check_val("badid_retry", 32'(retry_count), 32'd3);
        check_val("badid_id_value", id_value, 32'd3);
        check_val("badid_tmo", 32'(timeout_err), 32'd0);
        id_bad = 1'b0;
        next_cycle();

        // 5 wait states per read: done at cycle 14, address held through stalls
        stall_n = 5;
        pulse_start(1'b0);
        for (int c = 1; c <= 12; c++) begin
            check_val("st_read", 32'(av_read), 32'd1);
            check_val("st_addr", 32'(av_address), (c <= 6) ? 32'd0 : 32'd1);
            next_cycle();
        end
        check_val("st_c13_read", 32'(av_read), 32'd0);
        check_val("st_c13_busy", 32'(busy), 32'd1);
        next_cycle();
        check_val("st_c14_done", 32'(done), 32'd1);
        check_val("st_pass", 32'(pass), 32'd1);
        stall_n = 0;
        next_cycle();

        // bad timestamp on first attempt only
        ts_bad_base = ts_reads;
        bad_ts_n = 1;
        pulse_start(1'b0);
        wait_done(1'b0, 100, k);
        check_val("badts_cycles", 32'(k), 32'd7);
        check_val("badts_pass", 32'(pass), 32'd1);
        check_val("badts_retry", 32'(retry_count), 32'd1);
        check_val("badts_ts_ok", 32'(ts_ok), 32'd1);
        bad_ts_n = 0;
        next_cycle();

        // permanent stall, TIMEOUT_CYCLES=8, MAX_RETRIES=1: two 8-cycle attempts
        pulse_start(1'b1);
        check_val("tmo_c1_read", 32'(av_read_t), 32'd1);
        wait_done(1'b1, 100, k);
        check_val("tmo_cycles", 32'(k), 32'd17);
        check_val("tmo_err", 32'(timeout_err_t), 32'd1);
        check_val("tmo_pass", 32'(pass_t), 32'd0);
        check_val("tmo_retry", 32'(retry_count_t), 32'd1);
        check_val("tmo_id_ok", 32'(id_ok_t), 32'd0);
        check_val("tmo_av_read", 32'(av_read_t), 32'd0);
        check_val("tmo_busy", 32'(busy_t), 32'd0);

        // reset during RD_TS
        pulse_start(1'b0);
        next_cycle();
        check_val("rr_in_rdts_addr", 32'(av_address), 32'd1);
        reset_n = 1'b0;
        next_cycle();
        check_val("rr_av_read", 32'(av_read), 32'd0);
        check_val("rr_busy", 32'(busy), 32'd0);
        check_val("rr_done", 32'(done), 32'd0);
        check_val("rr_pass", 32'(pass), 32'd0);
        check_val("rr_id_ok", 32'(id_ok), 32'd0);
        check_val("rr_id_value", id_value, 32'd0);
        check_val("rr_addr", 32'(av_address), 32'd0);
        reset_n = 1'b1;
        next_cycle();

        // start during RD_TS must be ignored
        pulse_start(1'b0);
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        check_val("ign_c2_addr", 32'(av_address), 32'd1);
        next_cycle();
        check_val("ign_c3_read", 32'(av_read), 32'd0);
        next_cycle();
        check_val("ign_c4_done", 32'(done), 32'd1);
        check_val("ign_pass", 32'(pass), 32'd1);

        // start in DONE relaunches
        pulse_start(1'b0);
        check_val("rl_done", 32'(done), 32'd0);
        check_val("rl_pass_clr", 32'(pass), 32'd0);
        check_val("rl_read", 32'(av_read), 32'd1);
        wait_done(1'b0, 100, k);
        check_val("rl_cycles", 32'(k), 32'd4);
        check_val("rl_pass", 32'(pass), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
